// File: rtl/nn_host_sequencer.sv
// Host-side driver for the NN top: loads weights/biases from a word ROM, then streams
// a batch of images from a pixel ROM and collects one predicted digit per image.
module nn_host_sequencer #(
    parameter int NUM_PIXELS = 784,
    parameter int L1_ROWS    = 784,
    parameter int L2_ROWS    = 32,
    parameter int WRITE_W    = 16,
    parameter int WADDR_W    = 12,
    parameter int PADDR_W    = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               skipLoad,
    input  logic [7:0]         numImages,
    output logic [WADDR_W-1:0] wordAddr,
    input  logic [WRITE_W-1:0] wordIn,
    output logic [PADDR_W-1:0] pixelAddr,
    input  logic               pixelIn,
    output logic               weightWriteEnable,
    output logic               biasWriteEnable,
    output logic               LayerWriteSelect,
    output logic [9:0]         WriteAddressSelect,
    output logic [WRITE_W-1:0] writeIn,
    input  logic               readyForInputs,
    output logic               inputsInbound,
    output logic               inputPixel,
    input  logic               predictionReady,
    input  logic [3:0]         predictionOut,
    output logic               predictionRecieved,
    output logic               resultValid,
    output logic [3:0]         resultDigit,
    output logic [7:0]         resultIndex,
    output logic               busy,
    output logic               done
);
    localparam int T   = L1_ROWS + L2_ROWS + 2;
    localparam int L1B = L1_ROWS;               // word index of the layer-1 bias
    localparam int L2B = L1_ROWS + L2_ROWS + 1; // word index of the layer-2 bias
    localparam int LCW = $clog2(T + 1);
    localparam int PCW = $clog2(NUM_PIXELS + 1);
    localparam logic [PADDR_W-1:0] NP_A = PADDR_W'(NUM_PIXELS);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, STREAM, WAIT_PRED, ACK, FINISH} stateT;

    stateT              state;
    logic [7:0]         numLatched;
    logic [7:0]         n;
    logic [LCW-1:0]     loadCnt;
    logic [PCW-1:0]     pixCnt;
    logic [PADDR_W-1:0] base;
    logic [8:0]         nNext;
    logic               nxtWeight, nxtBias, nxtLayer;
    logic [9:0]         nxtRow;

    assign nNext      = {1'b0, n} + 9'd1;
    assign busy       = (state != IDLE);
    assign writeIn    = (weightWriteEnable || biasWriteEnable) ? wordIn : '0;
    assign inputPixel = inputsInbound & pixelIn;

    // Section decode for the word being fetched this cycle; its write lands next cycle.
    always_comb begin
        nxtWeight = 1'b0;
        nxtBias   = 1'b0;
        nxtLayer  = 1'b0;
        nxtRow    = '0;
        if (loadCnt < LCW'(L1B)) begin
            nxtWeight = 1'b1;
            nxtRow    = 10'(loadCnt);
        end else if (loadCnt == LCW'(L1B)) begin
            nxtBias = 1'b1;
        end else if (loadCnt < LCW'(L2B)) begin
            nxtWeight = 1'b1;
            nxtLayer  = 1'b1;
            nxtRow    = 10'(loadCnt - LCW'(L1B + 1));
        end else begin
            nxtBias  = 1'b1;
            nxtLayer = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            numLatched         <= '0;
            n                  <= '0;
            loadCnt            <= '0;
            pixCnt             <= '0;
            base               <= '0;
            wordAddr           <= '0;
            pixelAddr          <= '0;
            weightWriteEnable  <= 1'b0;
            biasWriteEnable    <= 1'b0;
            LayerWriteSelect   <= 1'b0;
            WriteAddressSelect <= '0;
            inputsInbound      <= 1'b0;
            predictionRecieved <= 1'b0;
            resultValid        <= 1'b0;
            resultDigit        <= '0;
            resultIndex        <= '0;
            done               <= 1'b0;
        end else begin
            resultValid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    numLatched <= numImages;
                    n          <= '0;
                    base       <= '0;
                    loadCnt    <= '0;
                    wordAddr   <= '0;
                    pixelAddr  <= '0;
                    if (!skipLoad)              state <= LOAD;
                    else if (numImages == 8'd0) state <= FINISH;
                    else                        state <= WAIT_RDY;
                end
                LOAD: begin
                    if (loadCnt == LCW'(T)) begin
                        weightWriteEnable  <= 1'b0;
                        biasWriteEnable    <= 1'b0;
                        LayerWriteSelect   <= 1'b0;
                        WriteAddressSelect <= '0;
                        wordAddr           <= '0;
                        state              <= (numLatched == 8'd0) ? FINISH : WAIT_RDY;
                    end else begin
                        weightWriteEnable  <= nxtWeight;
                        biasWriteEnable    <= nxtBias;
                        LayerWriteSelect   <= nxtLayer;
                        WriteAddressSelect <= nxtRow;
                        wordAddr           <= WADDR_W'(loadCnt + LCW'(1));
                        loadCnt            <= loadCnt + LCW'(1);
                    end
                end
                WAIT_RDY: begin
                    // Address of pixel 0 is held so its data is already out when streaming starts.
                    pixelAddr <= base;
                    if (readyForInputs) begin
                        state         <= STREAM;
                        inputsInbound <= 1'b1;
                        pixelAddr     <= base + PADDR_W'(1);
                        pixCnt        <= '0;
                    end
                end
                STREAM: begin
                    if (pixCnt == PCW'(NUM_PIXELS - 1)) begin
                        inputsInbound <= 1'b0;
                        state         <= WAIT_PRED;
                    end else begin
                        pixCnt    <= pixCnt + PCW'(1);
                        pixelAddr <= pixelAddr + PADDR_W'(1);
                    end
                end
                WAIT_PRED: if (predictionReady) begin
                    resultDigit        <= predictionOut;
                    predictionRecieved <= 1'b1;
                    state              <= ACK;
                end
                ACK: if (!predictionReady) begin
                    predictionRecieved <= 1'b0;
                    resultValid        <= 1'b1;
                    resultIndex        <= n;
                    n                  <= n + 8'd1;
                    base               <= base + NP_A;
                    pixelAddr          <= base + NP_A;
                    state              <= (nNext < {1'b0, numLatched}) ? WAIT_RDY : FINISH;
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_host_sequencer.sv
// Bench for nn_host_sequencer: each batch is planned as a per-cycle timeline of
// expected outputs derived from the protocol rules, then replayed and compared.
module tb_nn_host_sequencer;
    localparam int NP = 8, L1 = 4, L2 = 2, WW = 8, WA = 12, PA = 18;
    localparam int T = L1 + L2 + 2;
    localparam int MAXC = 512;

    logic clk = 1'b0, rst;
    logic start, skipLoad;
    logic [7:0] numImages;
    logic [WA-1:0] wordAddr;
    logic [WW-1:0] wordIn;
    logic [PA-1:0] pixelAddr;
    logic pixelIn;
    logic weightWriteEnable, biasWriteEnable, LayerWriteSelect;
    logic [9:0] WriteAddressSelect;
    logic [WW-1:0] writeIn;
    logic readyForInputs, inputsInbound, inputPixel, predictionReady;
    logic [3:0] predictionOut;
    logic predictionRecieved, resultValid, busy, done;
    logic [3:0] resultDigit;
    logic [7:0] resultIndex;

    nn_host_sequencer #(.NUM_PIXELS(NP), .L1_ROWS(L1), .L2_ROWS(L2), .WRITE_W(WW),
                        .WADDR_W(WA), .PADDR_W(PA)) dut (
        .clk(clk), .reset(rst), .start(start), .skipLoad(skipLoad), .numImages(numImages),
        .wordAddr(wordAddr), .wordIn(wordIn), .pixelAddr(pixelAddr), .pixelIn(pixelIn),
        .weightWriteEnable(weightWriteEnable), .biasWriteEnable(biasWriteEnable),
        .LayerWriteSelect(LayerWriteSelect), .WriteAddressSelect(WriteAddressSelect),
        .writeIn(writeIn), .readyForInputs(readyForInputs), .inputsInbound(inputsInbound),
        .inputPixel(inputPixel), .predictionReady(predictionReady), .predictionOut(predictionOut),
        .predictionRecieved(predictionRecieved), .resultValid(resultValid),
        .resultDigit(resultDigit), .resultIndex(resultIndex), .busy(busy), .done(done));

    always #5 clk = ~clk;

    logic [WW-1:0] wordRom [0:T-1];
    logic          pixRom  [0:255];
    logic [7:0]    pat;
    always @(posedge clk) begin
        wordIn  <= wordRom[wordAddr[2:0]];
        pixelIn <= pixRom[pixelAddr[7:0]];
    end

    // Planned timeline, cycle 0 = the cycle start is presented.
    bit eBusy[MAXC], eWe[MAXC], eBe[MAXC], eLay[MAXC], eIn[MAXC], ePix[MAXC];
    bit eAck[MAXC], eVal[MAXC], eDone[MAXC], chkWA[MAXC], chkPA[MAXC];
    bit iRdy[MAXC], iPred[MAXC], iStart[MAXC], capAt[MAXC], idxAt[MAXC];
    int eRow[MAXC], eWA[MAXC], ePA[MAXC], eDig[MAXC], eIdx[MAXC], capD[MAXC], idxV[MAXC];
    logic [WW-1:0] eData[MAXC];
    logic [3:0] iDig[MAXC];
    int len, bSkip, bNum, heldDig, heldIdx, cyc;
    bit active;
    int total = 0, bad = 0;

    int obsWr, obsPixCnt, obsVal, obsDone, doneCyc;
    int obsValIdx[4];
    logic [WW-1:0] obsFirstData, obsLastData;
    logic [15:0] obsPix;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic plan(input int skip, input int num, input int fDr, input int fH, input int fDig);
        int p, s, w, a, r, dr, dp, h, dig;
        for (int c = 0; c < MAXC; c++) begin
            eBusy[c] = 0; eWe[c] = 0; eBe[c] = 0; eLay[c] = 0; eIn[c] = 0; ePix[c] = 0;
            eAck[c] = 0; eVal[c] = 0; eDone[c] = 0; chkWA[c] = 0; chkPA[c] = 0;
            iRdy[c] = 0; iPred[c] = 0; iStart[c] = 0; capAt[c] = 0; idxAt[c] = 0;
            eRow[c] = 0; eWA[c] = 0; ePA[c] = 0; eData[c] = '0; capD[c] = 0; idxV[c] = 0;
            iDig[c] = 4'($urandom);
        end
        bSkip = skip; bNum = num; iStart[0] = 1; p = 1;
        if (skip == 0) begin
            for (int c = 1; c <= T + 1; c++) eBusy[c] = 1;
            for (int j = 0; j < T; j++) begin
                chkWA[j+1] = 1; eWA[j+1] = j;
                eData[j+2] = wordRom[j];
                if (j < L1) begin eWe[j+2] = 1; eRow[j+2] = j; end
                else if (j == L1) eBe[j+2] = 1;
                else if (j < L1 + L2 + 1) begin eWe[j+2] = 1; eLay[j+2] = 1; eRow[j+2] = j - L1 - 1; end
                else begin eBe[j+2] = 1; eLay[j+2] = 1; end
            end
            p = T + 2;
        end
        for (int i = 0; i < num; i++) begin
            dr  = (fDr >= 0) ? fDr : int'($urandom_range(0, 4));
            dp  = int'($urandom_range(0, 3));
            h   = (fH > 0) ? fH : int'($urandom_range(1, 6));
            dig = (fDig >= 0) ? fDig : int'($urandom_range(0, 9));
            for (int c = p; c <= p + dr; c++) begin eBusy[c] = 1; chkPA[c] = 1; ePA[c] = i * NP; end
            iRdy[p+dr] = 1;
            s = p + dr + 1;
            for (int k = 0; k < NP; k++) begin
                eBusy[s+k] = 1; eIn[s+k] = 1; ePix[s+k] = pixRom[i*NP+k];
                chkPA[s+k] = 1; ePA[s+k] = i * NP + k + 1;
                iRdy[s+k] = 1'($urandom_range(0, 1));
            end
            w = s + NP;
            for (int c = w; c <= w + dp; c++) eBusy[c] = 1;
            for (int c = w + dp; c < w + dp + h; c++) begin iPred[c] = 1; iDig[c] = 4'(dig); end
            a = w + dp + 1;
            capAt[a] = 1; capD[a] = dig;
            for (int c = a; c <= w + dp + h; c++) begin eAck[c] = 1; eBusy[c] = 1; end
            r = w + dp + h + 1;
            eVal[r] = 1; idxAt[r] = 1; idxV[r] = i;
            p = r;
        end
        eBusy[p] = 1; eDone[p+1] = 1; len = p + 4;
        for (int c = 1; c <= p; c++) iStart[c] = ($urandom_range(0, 3) == 0);
        for (int c = 0; c < len; c++) begin
            if (capAt[c]) heldDig = capD[c];
            if (idxAt[c]) heldIdx = idxV[c];
            eDig[c] = heldDig; eIdx[c] = heldIdx;
        end
    endtask

    task automatic runBatch();
        for (int c = 0; c < len; c++) begin
            start           = iStart[c];
            skipLoad        = (c == 0) ? 1'(bSkip) : 1'($urandom_range(0, 1));
            numImages       = (c == 0) ? 8'(bNum) : 8'($urandom);
            readyForInputs  = iRdy[c];
            predictionReady = iPred[c];
            predictionOut   = iDig[c];
            cyc = c; active = 1;
            @(posedge clk); #1;
        end
        active = 0; start = 0; readyForInputs = 0; predictionReady = 0;
    endtask

    always @(negedge clk) if (active) begin
        if (cyc == 0) begin
            obsWr = 0; obsPixCnt = 0; obsVal = 0; obsDone = 0; doneCyc = -1; obsPix = '0;
            obsFirstData = '0; obsLastData = '0;
        end
        chk("busy", int'(busy), int'(eBusy[cyc]));
        chk("weightWE", int'(weightWriteEnable), int'(eWe[cyc]));
        chk("biasWE", int'(biasWriteEnable), int'(eBe[cyc]));
        if (eWe[cyc] || eBe[cyc]) begin
            chk("layerSel", int'(LayerWriteSelect), int'(eLay[cyc]));
            chk("rowSel", int'(WriteAddressSelect), eRow[cyc]);
            chk("writeIn", int'(writeIn), int'(eData[cyc]));
        end
        if (chkWA[cyc]) chk("wordAddr", int'(wordAddr), eWA[cyc]);
        chk("inbound", int'(inputsInbound), int'(eIn[cyc]));
        if (eIn[cyc]) chk("pixel", int'(inputPixel), int'(ePix[cyc]));
        if (chkPA[cyc]) chk("pixelAddr", int'(pixelAddr), ePA[cyc]);
        chk("predRecv", int'(predictionRecieved), int'(eAck[cyc]));
        chk("resultValid", int'(resultValid), int'(eVal[cyc]));
        chk("done", int'(done), int'(eDone[cyc]));
        chk("resultDigit", int'(resultDigit), eDig[cyc]);
        chk("resultIndex", int'(resultIndex), eIdx[cyc]);
        if (weightWriteEnable || biasWriteEnable) begin
            if (obsWr == 0) obsFirstData = writeIn;
            obsLastData = writeIn; obsWr++;
        end
        if (inputsInbound) begin obsPix = {obsPix[14:0], inputPixel}; obsPixCnt++; end
        if (resultValid) begin if (obsVal < 4) obsValIdx[obsVal] = int'(resultIndex); obsVal++; end
        if (done) begin obsDone++; doneCyc = cyc; end
    end

    initial begin
        rst = 1; start = 0; skipLoad = 0; numImages = 0; readyForInputs = 0;
        predictionReady = 0; predictionOut = 0; active = 0; cyc = 0; heldDig = 0; heldIdx = 0;
        pat = 8'b10110010;
        for (int j = 0; j < T; j++) wordRom[j] = 8'(j * 17 + 3);
        for (int i = 0; i < 256; i++) pixRom[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) pixRom[i] = pat[7-i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst strobes", int'(weightWriteEnable | biasWriteEnable), 0);
        chk("rst inbound", int'(inputsInbound), 0);
        chk("rst wordAddr", int'(wordAddr), 0);
        chk("rst pixelAddr", int'(pixelAddr), 0);
        chk("rst done/valid", int'(done | resultValid | predictionRecieved), 0);
        chk("rst digit/index", int'(resultDigit) + int'(resultIndex), 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        // full load, one image, ready after 3 cycles, prediction held 5 cycles with digit 7
        plan(0, 1, 3, 5, 7); runBatch();
        chk("lit writes", obsWr, 8);
        chk("lit firstData", int'(obsFirstData), 8'h03);
        chk("lit lastData", int'(obsLastData), 8'h7A);
        chk("lit pixels", int'(obsPix[7:0]), 8'hB2);
        chk("lit pixCount", obsPixCnt, 8);
        chk("lit digit", int'(resultDigit), 7);
        chk("lit index", int'(resultIndex), 0);
        chk("lit valids", obsVal, 1);
        chk("lit dones", obsDone, 1);

        // two images, load skipped
        plan(1, 2, -1, -1, -1); runBatch();
        chk("lit2 pixCount", obsPixCnt, 16);
        chk("lit2 firstImg", int'(obsPix[15:8]), 8'hB2);
        chk("lit2 valids", obsVal, 2);
        chk("lit2 idx0", obsValIdx[0], 0);
        chk("lit2 idx1", obsValIdx[1], 1);
        chk("lit2 dones", obsDone, 1);

        // empty batch, load skipped
        plan(1, 0, -1, -1, -1); runBatch();
        chk("lit3 doneCyc", doneCyc, 2);
        chk("lit3 writes", obsWr, 0);
        chk("lit3 pixCount", obsPixCnt, 0);

        // reset in the middle of the weight load
        start = 1; skipLoad = 0; numImages = 1;
        @(posedge clk); #1 start = 0;
        repeat (4) @(posedge clk);
        #1 chk("preRst weightWE", int'(weightWriteEnable), 1);
        #2 rst = 1;
        @(negedge clk);
        chk("midRst strobes", int'(weightWriteEnable | biasWriteEnable), 0);
        chk("midRst busy", int'(busy), 0);
        @(negedge clk);
        chk("midRst hold", int'(weightWriteEnable | biasWriteEnable | busy), 0);
        @(posedge clk); #1 rst = 0;
        heldDig = 0; heldIdx = 0;
        @(posedge clk); #1;

        for (int b = 0; b < 20; b++) begin
            plan(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), -1, -1, -1);
            runBatch();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
